operand_loader: RTL and testbench

- Upstream feeder for the 8-bit multiplier/ALU datapath on the lab board.
- Captures operand A, then operand B, from the slide switches on debounced presses of a load button.
- Holds both operands stable on `a`/`b` and signals availability with a valid/ready handshake.
- A clear button aborts entry at any time and zeroes both operands.

---
 rtl/operand_loader_pkg.sv | 12 +
 rtl/operand_loader_btn_debounce.sv | 45 ++++
 rtl/operand_loader.sv | 96 +++++++++
 tb/tb_operand_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// rtl/operand_loader_pkg.sv - shared types and defaults for the operand loader
package operand_loader_pkg;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    VALID  = 2'd2
  } opld_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/operand_loader_btn_debounce.sv
// rtl/operand_loader_btn_debounce.sv - button synchronizer, debouncer and press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      // any sample agreeing with the accepted level restarts the count
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - captures operands A then B from switches on load presses
// OPERAND_LOADER_NIBBLE_MASK_EN: captures keep only the lower half of sw.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  input  logic             op_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             op_valid,
  output logic [1:0]       state_o
);

  opld_state_t      state;
  opld_state_t      state_n;
  logic [WIDTH-1:0] a_n;
  logic [WIDTH-1:0] b_n;
  logic [WIDTH-1:0] cap;
  logic             load_press;
  logic             clear_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_load),
    .press (load_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clear),
    .press (clear_press)
  );

`ifdef OPERAND_LOADER_NIBBLE_MASK_EN
  assign cap = {{(WIDTH - WIDTH/2){1'b0}}, sw[WIDTH/2-1:0]};
`else
  assign cap = sw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WAIT_A;
      a        <= '0;
      b        <= '0;
      op_valid <= 1'b0;
    end else begin
      state    <= state_n;
      a        <= a_n;
      b        <= b_n;
      op_valid <= (state_n == VALID);
    end
  end

  // clear outranks load and op_ready in the same cycle
  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    if (clear_press) begin
      state_n = WAIT_A;
      a_n     = '0;
      b_n     = '0;
    end else begin
      case (state)
        WAIT_A: begin
          if (load_press) begin
            a_n     = cap;
            state_n = WAIT_B;
          end
        end
        WAIT_B: begin
          if (load_press) begin
            b_n     = cap;
            state_n = VALID;
          end
        end
        VALID: begin
          if (op_ready) state_n = WAIT_A;
        end
        default: state_n = WAIT_A;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - randomized and directed bench for operand_loader
module tb_operand_loader;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic         btn_load;
  logic         btn_clear;
  logic         op_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op_valid;
  logic [1:0]   state_o;

  int checks = 0;
  int errors = 0;

  operand_loader #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_load  (btn_load),
    .btn_clear (btn_clear),
    .op_ready  (op_ready),
    .a         (a),
    .b         (b),
    .op_valid  (op_valid),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] cap_f(input logic [W-1:0] v);
`ifdef OPERAND_LOADER_NIBBLE_MASK_EN
    return {4'h0, v[3:0]};
`else
    return v;
`endif
  endfunction

  // Reference model: a button change is accepted after D consecutive raw samples
  // at the new level; a press acts on the FSM 3 edges after the D-th sample.
  int           edge_n = 0;
  int           ld_run, cl_run;
  logic         ld_deb, cl_deb;
  int           ld_q[$];
  int           cl_q[$];
  logic         ld_ev, cl_ev;
  logic [W-1:0] m_a, m_b;
  logic         m_valid;
  logic [1:0]   m_st;

  task model_step();
    edge_n = edge_n + 1;
    if (rst) begin
      ld_run = 0; cl_run = 0; ld_deb = 0; cl_deb = 0;
      ld_q.delete(); cl_q.delete();
      m_a = 0; m_b = 0; m_valid = 0; m_st = 0;
    end else begin
      ld_ev = 0; cl_ev = 0;
      if (ld_q.size() > 0 && ld_q[0] == edge_n) begin ld_ev = 1; void'(ld_q.pop_front()); end
      if (cl_q.size() > 0 && cl_q[0] == edge_n) begin cl_ev = 1; void'(cl_q.pop_front()); end
      if (cl_ev) begin
        m_st = 0; m_a = 0; m_b = 0;
      end else if (m_st == 0 && ld_ev) begin
        m_a = cap_f(sw); m_st = 1;
      end else if (m_st == 1 && ld_ev) begin
        m_b = cap_f(sw); m_st = 2;
      end else if (m_st == 2 && op_ready) begin
        m_st = 0;
      end
      m_valid = (m_st == 2);
      if (btn_load != ld_deb) begin
        ld_run = ld_run + 1;
        if (ld_run == D) begin
          ld_deb = btn_load; ld_run = 0;
          if (btn_load) ld_q.push_back(edge_n + 3);
        end
      end else ld_run = 0;
      if (btn_clear != cl_deb) begin
        cl_run = cl_run + 1;
        if (cl_run == D) begin
          cl_deb = btn_clear; cl_run = 0;
          if (btn_clear) cl_q.push_back(edge_n + 3);
        end
      end else cl_run = 0;
    end
  endtask

  always @(posedge clk) model_step();

  task automatic press(input logic [W-1:0] v, input int hold, input int gap);
    @(negedge clk);
    sw = v; btn_load = 1'b1;
    repeat (hold) @(negedge clk);
    btn_load = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = '0; btn_load = 0; btn_clear = 0; op_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (a !== 8'h00) begin errors++; $display("FAIL reset_a got %h want 00", a); end
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL reset_b got %h want 00", b); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", op_valid); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
  endtask

  task automatic test_capture();
    sw = 8'h35; btn_load = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (a !== 8'h00) begin errors++; $display("FAIL early_a got %h want 00", a); end
    @(negedge clk);
    checks++; if (a !== cap_f(8'h35) || state_o !== 2'd1) begin
      errors++; $display("FAIL capture_a got a=%h st=%0d want a=%h st=1", a, state_o, cap_f(8'h35)); end
    repeat (3) @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    press(8'h0C, 10, 10);
    checks++; if (b !== cap_f(8'h0C) || state_o !== 2'd2 || op_valid !== 1'b1) begin
      errors++; $display("FAIL capture_b got b=%h st=%0d v=%b want b=%h st=2 v=1", b, state_o, op_valid, cap_f(8'h0C)); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d got %b want 1", i, op_valid); end
    end
  endtask

  task automatic test_handshake();
    press(8'h77, 10, 10);
    checks++; if (a !== cap_f(8'h35) || b !== cap_f(8'h0C) || state_o !== 2'd2) begin
      errors++; $display("FAIL load_in_valid got a=%h b=%h st=%0d want a=%h b=%h st=2", a, b, state_o, cap_f(8'h35), cap_f(8'h0C)); end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    checks++; if (op_valid !== 1'b0 || state_o !== 2'd0) begin
      errors++; $display("FAIL accept got v=%b st=%0d want v=0 st=0", op_valid, state_o); end
    checks++; if (a !== cap_f(8'h35) || b !== cap_f(8'h0C)) begin
      errors++; $display("FAIL retain got a=%h b=%h want a=%h b=%h", a, b, cap_f(8'h35), cap_f(8'h0C)); end
  endtask

  task automatic test_bounce();
    sw = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      btn_load = 1'b1; repeat (2) @(negedge clk);
      btn_load = 1'b0; repeat (2) @(negedge clk);
    end
    btn_load = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (a !== cap_f(8'h35)) begin errors++; $display("FAIL bounce_early got %h want %h", a, cap_f(8'h35)); end
    @(negedge clk);
    checks++; if (a !== cap_f(8'h5A) || state_o !== 2'd1) begin
      errors++; $display("FAIL bounce_capture got a=%h st=%0d want a=%h st=1", a, state_o, cap_f(8'h5A)); end
    repeat (5) @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL bounce_once got st=%0d want 1", state_o); end
  endtask

  task automatic test_clear_load();
    sw = 8'h3C; btn_load = 1'b1; btn_clear = 1'b1;
    repeat (7) @(negedge clk);
    checks++; if (a !== 8'h00 || b !== 8'h00 || state_o !== 2'd0 || op_valid !== 1'b0) begin
      errors++; $display("FAIL clear_wins got a=%h b=%h st=%0d v=%b want 00 00 0 0", a, b, state_o, op_valid); end
    btn_load = 1'b0; btn_clear = 1'b0;
    repeat (10) @(negedge clk);
    sw = 8'h81; btn_load = 1'b1;
    repeat (2) @(negedge clk);
    btn_load = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (a !== 8'h00 || state_o !== 2'd0) begin
      errors++; $display("FAIL rst_mid_debounce got a=%h st=%0d want 00 0", a, state_o); end
  endtask

  task automatic test_hold_through_reset();
    sw = 8'hC3; btn_load = 1'b1; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (a !== 8'h00) begin errors++; $display("FAIL held_early got %h want 00", a); end
    @(negedge clk);
    checks++; if (a !== cap_f(8'hC3) || state_o !== 2'd1) begin
      errors++; $display("FAIL held_press got a=%h st=%0d want a=%h st=1", a, state_o, cap_f(8'hC3)); end
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    int ld_hold = 0;
    int cl_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if ({a, b, op_valid, state_o} !== {m_a, m_b, m_valid, m_st}) begin
        errors++;
        $display("FAIL random cyc %0d got a=%h b=%h v=%b st=%0d want a=%h b=%h v=%b st=%0d",
                 i, a, b, op_valid, state_o, m_a, m_b, m_valid, m_st);
      end
      if (ld_hold == 0) begin btn_load = ($urandom_range(0, 1) == 1); ld_hold = $urandom_range(1, 12); end
      else ld_hold--;
      if (cl_hold == 0) begin btn_clear = ($urandom_range(0, 9) == 0); cl_hold = $urandom_range(1, 10); end
      else cl_hold--;
      op_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) sw = W'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    btn_load = 0; btn_clear = 0; op_ready = 0; rst = 0;
  endtask

  task automatic test_mask();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    press(8'hF7, 10, 10);
    press(8'hA9, 10, 10);
`ifdef OPERAND_LOADER_NIBBLE_MASK_EN
    checks++; if (a !== 8'h07 || b !== 8'h09) begin
      errors++; $display("FAIL mask got a=%h b=%h want a=07 b=09", a, b); end
`else
    checks++; if (a !== 8'hF7 || b !== 8'hA9) begin
      errors++; $display("FAIL full_capture got a=%h b=%h want a=F7 b=A9", a, b); end
`endif
  endtask

  initial begin
    test_reset();
    test_capture();
    test_handshake();
    test_bounce();
    test_clear_load();
    test_hold_through_reset();
    test_random();
    test_mask();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
